ad_frame_unpack: RTL and testbench

//  Reader end of the ADC packet stream. Drains packed 32-bit words from one channel's data FIFO
//  (standard-mode FIFO, dout valid 1 cycle after rd_en) and hunts for frame headers.

---
 rtl/ad_pkt_pkg.sv | 38 +++
 rtl/ad_sample_splitter.sv | 55 +++++
 rtl/ad_frame_unpack.sv | 199 +++++++++++++++++++
 tb/tb_ad_frame_unpack.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_pkt_pkg.sv
// ADC packet word format shared between the packing and unpacking ends.
// Holds the header/tail tags, word-field positions and widths, the
// unpacker FSM state codes and a saturating-increment helper.
package ad_pkt_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned SAMPLE_W  = 14;
    localparam int unsigned CNT_W     = 16;

    // Word field positions (LSB) and widths
    localparam int unsigned TAG_LSB   = 16;
    localparam int unsigned TAG_W     = 16;
    localparam int unsigned TYPE_LSB  = 30;
    localparam int unsigned TYPE_W    = 2;
    localparam int unsigned S1_LSB    = 16;
    localparam int unsigned S0_LSB    = 0;
    localparam int unsigned CHIP_LSB  = 8;
    localparam int unsigned CHIP_W    = 4;
    localparam int unsigned FRAME_LSB = 0;
    localparam int unsigned FRAME_W   = 8;
    localparam int unsigned COUNT_LSB = 0;
    localparam int unsigned COUNT_W   = 16;

    localparam logic [TAG_W-1:0] HEADER_TAG = 16'hAA55;
    localparam logic [TAG_W-1:0] TAIL_TAG   = 16'h5AA5;

    // Unpacker FSM states
    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

    // Error counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ad_sample_splitter.sv
// One-word unpack buffer: presents s0 then s1 of a loaded data word on a
// ready/valid sample port.
//   clk, reset    : clock, synchronous active-high reset
//   load          : capture s0/s1 (only asserted while the buffer is free)
//   s0, s1        : the two samples of the captured word
//   ready         : downstream accepts the presented sample
//   valid, data   : registered sample output
//   accept_c      : a sample is accepted this cycle
//   free_c        : buffer is empty or is handing over its last sample now
module ad_sample_splitter
    import ad_pkt_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SAMPLE_W-1:0] s0,
    input  logic [SAMPLE_W-1:0] s1,
    input  logic                ready,
    output logic                valid,
    output logic [SAMPLE_W-1:0] data,
    output logic                accept_c,
    output logic                free_c
);

    logic [SAMPLE_W-1:0] s1_hold;
    logic                on_s1;

    assign accept_c = valid & ready;
    // Freeing on the s1 handshake lets the next read overlap the last sample
    assign free_c   = ~valid | (accept_c & on_s1);

    // Sample sequencing: s0, then s1, each held until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            data    <= '0;
            s1_hold <= '0;
            on_s1   <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            data    <= s0;
            s1_hold <= s1;
            on_s1   <= 1'b0;
        end else if (accept_c) begin
            if (on_s1) begin
                valid <= 1'b0;
                on_s1 <= 1'b0;
            end else begin
                data  <= s1_hold;
                on_s1 <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ad_frame_unpack.sv
// Reader end of the ADC packet stream: drains a standard-mode FIFO, hunts
// for frame headers, unpacks two 14-bit samples per data word and checks
// the tail word count and frame-number continuity.
//   clk_100m, reset      : clock, synchronous active-high reset
//   fifo_empty/dout/rd_en: upstream FIFO (dout valid one cycle after rd_en)
//   sample_ready/valid   : downstream sample handshake
//   sample_data/index    : pixel sample and its index within the frame
//   frame_chip/num       : fields of the current header
//   frame_done/ok        : one-cycle tail verdict
//   err_format, err_gap  : saturating error counters
module ad_frame_unpack
    import ad_pkt_pkg::*;
#(
    parameter int unsigned PIXELS = 5184
)(
    input  logic                clk_100m,
    input  logic                reset,
    input  logic                fifo_empty,
    input  logic [WORD_W-1:0]   fifo_dout,
    output logic                fifo_rd_en,
    input  logic                sample_ready,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic [CNT_W-1:0]    sample_index,
    output logic [CHIP_W-1:0]   frame_chip,
    output logic [FRAME_W-1:0]  frame_num,
    output logic                frame_done,
    output logic                frame_ok,
    output logic [CNT_W-1:0]    err_format,
    output logic [CNT_W-1:0]    err_gap
);

    localparam int unsigned        WORDS     = PIXELS / 2;
    localparam logic [CNT_W-1:0]   WORDS_C   = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(WORDS) - CNT_W'(1);

    logic [1:0]           state;
    logic [1:0]           state_d;
    logic                 in_flight;
    logic                 first_frame;
    logic [CNT_W-1:0]     word_cnt;
    logic [CHIP_W-1:0]    hdr_chip;
    logic [FRAME_W-1:0]   hdr_frame;
    logic [FRAME_W-1:0]   prev_frame;

    logic                 want_c;
    logic                 buf_free_c;
    logic                 accept_c;
    logic                 is_header_c;
    logic                 is_tail_c;
    logic                 is_data_c;
    logic                 count_ok_c;
    logic                 cap_header_c;
    logic                 buf_load_c;
    logic                 fmt_err_c;
    logic                 done_c;
    logic                 ok_c;

    // Word classification of the captured FIFO word
    assign is_header_c = (fifo_dout[TAG_LSB +: TAG_W] == HEADER_TAG);
    assign is_tail_c   = (fifo_dout[TAG_LSB +: TAG_W] == TAIL_TAG);
    assign is_data_c   = (fifo_dout[TYPE_LSB +: TYPE_W] == 2'b00);
    assign count_ok_c  = (fifo_dout[COUNT_LSB +: COUNT_W] == WORDS_C);

    // HDR is the only state that consumes no word; TAIL waits on the buffer via buf_free_c
    assign want_c     = (state != ST_HDR);
    assign fifo_rd_en = ~reset & ~fifo_empty & want_c & ~in_flight & buf_free_c;

    // State register
    always_ff @(posedge clk_100m) begin
        if (reset) begin
            state <= ST_HUNT;
        end else begin
            state <= state_d;
        end
    end

    // Next state and per-word decisions
    always_comb begin
        state_d      = state;
        cap_header_c = 1'b0;
        buf_load_c   = 1'b0;
        fmt_err_c    = 1'b0;
        done_c       = 1'b0;
        ok_c         = 1'b0;
        case (state)
            ST_HUNT: begin
                if (in_flight && is_header_c) begin
                    cap_header_c = 1'b1;
                    state_d      = ST_HDR;
                end
            end
            ST_HDR: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (in_flight) begin
                    if (is_data_c) begin
                        buf_load_c = 1'b1;
                        if (word_cnt == LAST_WORD) begin
                            state_d = ST_TAIL;
                        end
                    end else if (is_header_c) begin
                        fmt_err_c    = 1'b1;
                        cap_header_c = 1'b1;
                        state_d      = ST_HDR;
                    end else begin
                        fmt_err_c = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_TAIL: begin
                if (in_flight) begin
                    done_c = 1'b1;
                    if (is_tail_c) begin
                        ok_c      = count_ok_c;
                        fmt_err_c = ~count_ok_c;
                        state_d   = ST_HUNT;
                    end else begin
                        fmt_err_c = 1'b1;
                        if (is_header_c) begin
                            cap_header_c = 1'b1;
                            state_d      = ST_HDR;
                        end else begin
                            state_d = ST_HUNT;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // Read tracking, header latch, counters and frame outputs
    always_ff @(posedge clk_100m) begin
        if (reset) begin
            in_flight    <= 1'b0;
            first_frame  <= 1'b1;
            word_cnt     <= '0;
            hdr_chip     <= '0;
            hdr_frame    <= '0;
            prev_frame   <= '0;
            sample_index <= '0;
            frame_chip   <= '0;
            frame_num    <= '0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            err_format   <= '0;
            err_gap      <= '0;
        end else begin
            in_flight  <= fifo_rd_en;
            frame_done <= done_c;
            frame_ok   <= ok_c;
            if (cap_header_c) begin
                hdr_chip  <= fifo_dout[CHIP_LSB +: CHIP_W];
                hdr_frame <= fifo_dout[FRAME_LSB +: FRAME_W];
            end
            if (fmt_err_c) begin
                err_format <= sat_inc(err_format);
            end
            if (state == ST_HDR) begin
                frame_chip   <= hdr_chip;
                frame_num    <= hdr_frame;
                prev_frame   <= hdr_frame;
                first_frame  <= 1'b0;
                word_cnt     <= '0;
                sample_index <= '0;
                // 8-bit add wraps, so 255 followed by 0 is continuous
                if (!first_frame && (hdr_frame != prev_frame + FRAME_W'(1))) begin
                    err_gap <= sat_inc(err_gap);
                end
            end else begin
                if (buf_load_c) begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
                if (accept_c) begin
                    sample_index <= sample_index + CNT_W'(1);
                end
            end
        end
    end

    ad_sample_splitter u_splitter (
        .clk      (clk_100m),
        .reset    (reset),
        .load     (buf_load_c),
        .s0       (fifo_dout[S0_LSB +: SAMPLE_W]),
        .s1       (fifo_dout[S1_LSB +: SAMPLE_W]),
        .ready    (sample_ready),
        .valid    (sample_valid),
        .data     (sample_data),
        .accept_c (accept_c),
        .free_c   (buf_free_c)
    );

endmodule

// File: tb/tb_ad_frame_unpack.sv
// Bench for ad_frame_unpack with PIXELS=8: a behavioural stream model
// predicts samples, frame verdicts and error counts; hand-computed
// literals pin the headline cases.
module tb_ad_frame_unpack;

    localparam int PIX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en;
    logic        sample_ready;
    logic        sample_valid;
    logic [13:0] sample_data;
    logic [15:0] sample_index;
    logic [3:0]  frame_chip;
    logic [7:0]  frame_num;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] err_format;
    logic [15:0] err_gap;

    ad_frame_unpack #(.PIXELS(PIX)) dut (
        .clk_100m     (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd_en   (fifo_rd_en),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_index (sample_index),
        .frame_chip   (frame_chip),
        .frame_num    (frame_num),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .err_format   (err_format),
        .err_gap      (err_gap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] q[$];
    int exp_data[$];
    int exp_idx[$];
    bit exp_ok[$];
    int exp_chip[$];
    int exp_frm[$];

    // Stream model: mode 0 = looking for header, 1 = collecting data, 2 = expecting tail
    int m_mode, m_words, m_idx, m_prev, m_chip, m_frame, m_efmt, m_egap;
    bit m_first;

    int got[$];
    int acc_cnt = 0;
    int done_cnt = 0;
    bit last_ok = 1'b0;
    int rdy_mode = 0;
    int pcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_words = 0; m_idx = 0; m_prev = 0;
        m_chip = 0; m_frame = 0; m_efmt = 0; m_egap = 0; m_first = 1'b1;
        exp_data.delete(); exp_idx.delete();
        exp_ok.delete(); exp_chip.delete(); exp_frm.delete();
    endfunction

    function automatic void model_hdr(input logic [31:0] w);
        if (!m_first && (int'(w[7:0]) != (m_prev + 1) % 256) && m_egap < 65535) m_egap++;
        m_first = 1'b0;
        m_prev  = int'(w[7:0]);
        m_chip  = int'(w[11:8]);
        m_frame = int'(w[7:0]);
        m_words = 0;
        m_idx   = 0;
        m_mode  = 1;
    endfunction

    function automatic void model_word(input logic [31:0] w);
        bit is_hdr = (w[31:16] == 16'hAA55);
        case (m_mode)
            0: if (is_hdr) model_hdr(w);
            1: begin
                if (w[31:30] == 2'b00) begin
                    exp_data.push_back(int'(w[13:0]));  exp_idx.push_back(m_idx);
                    exp_data.push_back(int'(w[29:16])); exp_idx.push_back(m_idx + 1);
                    m_idx += 2;
                    m_words++;
                    if (m_words == PIX / 2) m_mode = 2;
                end else begin
                    if (m_efmt < 65535) m_efmt++;
                    if (is_hdr) model_hdr(w); else m_mode = 0;
                end
            end
            default: begin
                exp_chip.push_back(m_chip);
                exp_frm.push_back(m_frame);
                if (w[31:16] == 16'h5AA5) begin
                    exp_ok.push_back(int'(w[15:0]) == PIX / 2);
                    if (int'(w[15:0]) != PIX / 2 && m_efmt < 65535) m_efmt++;
                    m_mode = 0;
                end else begin
                    exp_ok.push_back(1'b0);
                    if (m_efmt < 65535) m_efmt++;
                    if (is_hdr) model_hdr(w); else m_mode = 0;
                end
            end
        endcase
    endfunction

    // One clock: compare at negedge, then update FIFO and ready after posedge
    task automatic cycle();
        bit rd;
        @(negedge clk);
        rd = fifo_rd_en;
        if (!reset) begin
            if (sample_valid) begin
                bit s1_acc;
                s1_acc = sample_ready && (exp_idx.size() > 0) && ((exp_idx[0] % 2) == 1);
                if (!s1_acc) check("rd_while_full", 32'(fifo_rd_en), 32'd0);
            end
            if (sample_valid && sample_ready) begin
                acc_cnt++;
                got.push_back(int'(sample_data));
                if (exp_data.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_sample: got %0h expected none", sample_data);
                end else begin
                    check("sample_data", 32'(sample_data), 32'(exp_data.pop_front()));
                    check("sample_index", 32'(sample_index), 32'(exp_idx.pop_front()));
                end
            end
            if (frame_done) begin
                done_cnt++;
                last_ok = frame_ok;
                if (exp_ok.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_frame_done: got 1 expected 0");
                end else begin
                    check("frame_ok", 32'(frame_ok), 32'(exp_ok.pop_front()));
                    check("done_chip", 32'(frame_chip), 32'(exp_chip.pop_front()));
                    check("done_num", 32'(frame_num), 32'(exp_frm.pop_front()));
                end
            end
        end
        @(posedge clk);
        #1;
        if (rd && q.size() > 0) fifo_dout = q.pop_front();
        fifo_empty = (q.size() == 0);
        case (rdy_mode)
            0: sample_ready = 1'b1;
            1: sample_ready = 1'($urandom_range(0, 1));
            default: begin
                sample_ready = ((pcnt % 4) == 0) || ((pcnt % 4) == 3);
                pcnt++;
            end
        endcase
    endtask

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        model_word(w);
        fifo_empty = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] fnum, input bit rnd, input int nwords,
                              input logic [15:0] tail_cnt, input bit with_tail);
        push({16'hAA55, 4'h1, 4'h2, fnum});
        for (int i = 0; i < nwords; i++) begin
            logic [13:0] a, b;
            a = rnd ? 14'($urandom) : 14'(2 * i + 1);
            b = rnd ? 14'($urandom) : 14'(2 * i);
            push({2'b00, b, 2'b00, a});
        end
        if (with_tail) push({16'h5AA5, tail_cnt});
    endtask

    // Run until the stream and all predictions are consumed, then compare counters
    task automatic drain(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 6 && n < 3000) begin
            cycle();
            n++;
            if (q.size() == 0 && exp_data.size() == 0 && exp_ok.size() == 0 && !sample_valid)
                quiet++;
            else
                quiet = 0;
        end
        if (quiet < 6) $display("FAIL drain_%s: got timeout expected idle", tag);
        check("drain_idle", 32'(quiet >= 6), 32'd1);
        check("err_format", 32'(err_format), 32'(m_efmt));
        check("err_gap", 32'(err_gap), 32'(m_egap));
        check("frame_chip", 32'(frame_chip), 32'(m_chip));
        check("frame_num", 32'(frame_num), 32'(m_frame));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_data"},  32'(sample_data), 32'd0);
        check({tag, "_index"}, 32'(sample_index), 32'd0);
        check({tag, "_chip"},  32'(frame_chip), 32'd0);
        check({tag, "_num"},   32'(frame_num), 32'd0);
        check({tag, "_done"},  32'(frame_done), 32'd0);
        check({tag, "_ok"},    32'(frame_ok), 32'd0);
        check({tag, "_efmt"},  32'(err_format), 32'd0);
        check({tag, "_egap"},  32'(err_gap), 32'd0);
        check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    endtask

    initial begin
        int lit[8];
        int d0;
        int a0;
        lit = '{1, 0, 3, 2, 5, 4, 7, 6};
        reset = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout = '0;
        sample_ready = 1'b1;
        model_reset();
        repeat (3) cycle();
        check_zero("reset");
        reset = 1'b0;

        // Garbage before any header is discarded silently
        push(32'h1234_5678);
        push(32'hFFFF_0000);
        drain("garbage");
        check("garbage_samples", 32'(got.size()), 32'd0);
        check("garbage_efmt", 32'(err_format), 32'd0);

        // Basic frame, ready held high
        got.delete();
        push_frame(8'd3, 1'b0, PIX / 2, 16'd4, 1'b1);
        drain("basic");
        check("basic_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < got.size()) check("basic_sample", 32'(got[i]), 32'(lit[i]));
        check("basic_chip", 32'(frame_chip), 32'd2);
        check("basic_num", 32'(frame_num), 32'd3);
        check("basic_done", 32'(done_cnt), 32'd1);
        check("basic_ok", 32'(last_ok), 32'd1);

        // Back-pressure: fixed 1-0-0-1 pattern, then random
        rdy_mode = 2;
        push_frame(8'd4, 1'b1, PIX / 2, 16'd4, 1'b1);
        drain("ready_pattern");
        rdy_mode = 1;
        push_frame(8'd5, 1'b1, PIX / 2, 16'd4, 1'b1);
        drain("ready_random");
        rdy_mode = 0;

        // Wrong tail count, then a header cutting a frame short
        d0 = done_cnt;
        push_frame(8'd6, 1'b1, PIX / 2, 16'd3, 1'b1);
        drain("bad_count");
        check("bad_count_done", 32'(done_cnt - d0), 32'd1);
        check("bad_count_ok", 32'(last_ok), 32'd0);
        check("bad_count_efmt", 32'(err_format), 32'd1);
        push_frame(8'd7, 1'b1, PIX / 2 - 1, 16'd0, 1'b0);
        push_frame(8'd8, 1'b1, PIX / 2, 16'd4, 1'b1);
        drain("resync");
        check("resync_efmt", 32'(err_format), 32'd2);
        check("resync_ok", 32'(last_ok), 32'd1);
        check("resync_num", 32'(frame_num), 32'd8);
        check("resync_egap", 32'(err_gap), 32'd0);

        // Reset in the middle of a frame's data
        a0 = acc_cnt;
        push_frame(8'd9, 1'b1, PIX / 2, 16'd4, 1'b1);
        for (int n = 0; n < 200 && (acc_cnt - a0) < 3; n++) cycle();
        check("mid_reset_reached", 32'((acc_cnt - a0) >= 3), 32'd1);
        reset = 1'b1;
        q.delete();
        fifo_empty = 1'b1;
        model_reset();
        cycle();
        reset = 1'b0;
        check_zero("mid_reset");

        // Frame numbers 254, 255, 0, 2: only the last step is a gap
        d0 = done_cnt;
        push_frame(8'd254, 1'b1, PIX / 2, 16'd4, 1'b1);
        drain("after_reset");
        check("after_reset_ok", 32'(last_ok), 32'd1);
        check("after_reset_egap", 32'(err_gap), 32'd0);
        push_frame(8'd255, 1'b1, PIX / 2, 16'd4, 1'b1);
        push_frame(8'd0, 1'b1, PIX / 2, 16'd4, 1'b1);
        push_frame(8'd2, 1'b1, PIX / 2, 16'd4, 1'b1);
        drain("gap");
        check("gap_egap", 32'(err_gap), 32'd1);
        check("gap_num", 32'(frame_num), 32'd2);
        check("gap_done", 32'(done_cnt - d0), 32'd4);
        check("gap_ok", 32'(last_ok), 32'd1);
        check("gap_efmt", 32'(err_format), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
